// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared constants for the instruction-side OBI arbiter
package cv32e40p_pkg;

    // Master identifiers as stored in the arbiter owner FIFO
    localparam logic INSTR_ARB_M0 = 1'b0;
    localparam logic INSTR_ARB_M1 = 1'b1;

endpackage

// File: rtl/cv32e40p_instr_obi_arbiter_if.sv
// rtl/cv32e40p_instr_obi_arbiter_if.sv - requester and instr bus signals of the OBI arbiter
interface cv32e40p_instr_obi_arbiter_if;

    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;

    logic        m1_req_i;
    logic [31:0] m1_addr_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;

    logic [31:0] m_rdata_o;
    logic        m_err_o;

    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;

    logic        busy_o;

    // Arbiter view
    modport slave (
        input  m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        output m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o,
        output m_rdata_o, m_err_o, instr_req_o, instr_addr_o, busy_o
    );

    // Requesters plus memory view
    modport master (
        output m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        input  m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o,
        input  m_rdata_o, m_err_o, instr_req_o, instr_addr_o, busy_o
    );

endinterface

// File: rtl/cv32e40p_fifo.sv
// rtl/cv32e40p_fifo.sv - small synchronous FIFO with optional fall-through
module cv32e40p_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  flush_but_first_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH:0]   cnt_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  push_ok, pop_ok;
    logic                  testmode_unused;

    // Pointers wrap at DEPTH, which need not fill the pointer width when DEPTH is 1
    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        if (p == ADDR_DEPTH'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign testmode_unused = testmode_i;
    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_ptr_q];

    // An empty fall-through FIFO hands a push straight to a same-cycle pop without storing it
    assign push_ok = push_i && !full_o && !(FALL_THROUGH && empty_o && pop_i);
    assign pop_ok  = pop_i && !empty_o;

    // Next pointer, count and storage contents
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else if (flush_but_first_i) begin
            if (!empty_o) begin
                wr_ptr_d = ptr_inc(rd_ptr_q);
                cnt_d    = (ADDR_DEPTH + 1)'(1);
            end
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cv32e40p_instr_obi_arbiter.sv
// rtl/cv32e40p_instr_obi_arbiter.sv - two-master round-robin arbiter for the instruction OBI port
module cv32e40p_instr_obi_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cv32e40p_instr_obi_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_OUTSTANDING);

    logic           last_q, last_d;
    logic           lock_q, lock_d;
    logic           lock_id_q, lock_id_d;
    logic [CNT_W:0] cnt_q;
    logic           sel;
    logic           sel_req;
    logic [31:0]    sel_addr;
    logic           req_int;
    logic           handshake;
    logic           pop;
    logic           fifo_empty;
    logic           fifo_full_unused;
    logic [0:0]     head;

    // Pick the master: a waited transfer keeps its owner, otherwise round-robin on ties
    always_comb begin
        sel = INSTR_ARB_M0;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (bus.m0_req_i && bus.m1_req_i) begin
            sel = ~last_q;
        end else if (bus.m1_req_i) begin
            sel = INSTR_ARB_M1;
        end
        sel_req  = (sel == INSTR_ARB_M1) ? bus.m1_req_i  : bus.m0_req_i;
        sel_addr = (sel == INSTR_ARB_M1) ? bus.m1_addr_i : bus.m0_addr_i;
    end

    // Only the registered count gates the request, so a response never frees a slot the same cycle
    assign req_int   = rst_n && sel_req && (cnt_q < MAX_CNT);
    assign handshake = req_int && bus.instr_gnt_i;
    // Responses with no recorded owner are dropped
    assign pop       = rst_n && bus.instr_rvalid_i && !fifo_empty;

    assign bus.instr_req_o  = req_int;
    assign bus.instr_addr_o = rst_n ? {sel_addr[31:2], 2'b00} : 32'h0;
    assign bus.m0_gnt_o     = handshake && (sel == INSTR_ARB_M0);
    assign bus.m1_gnt_o     = handshake && (sel == INSTR_ARB_M1);
    assign bus.m0_rvalid_o  = pop && (head == INSTR_ARB_M0);
    assign bus.m1_rvalid_o  = pop && (head == INSTR_ARB_M1);
    assign bus.m_rdata_o    = rst_n ? bus.instr_rdata_i : 32'h0;
    assign bus.m_err_o      = rst_n && bus.instr_err_i;
    assign bus.busy_o       = (cnt_q != '0);

    // Next round-robin pointer and lock; the lock lasts exactly as long as the request waits
    always_comb begin
        last_d    = handshake ? sel : last_q;
        lock_d    = req_int && !bus.instr_gnt_i;
        lock_id_d = lock_d ? sel : lock_id_q;
    end

    // Arbitration state register; master 0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= INSTR_ARB_M1;
            lock_q    <= 1'b0;
            lock_id_q <= INSTR_ARB_M0;
        end else begin
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    cv32e40p_fifo #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (1),
        .DEPTH        (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .flush_i           (1'b0),
        .flush_but_first_i (1'b0),
        .testmode_i        (1'b0),
        .full_o            (fifo_full_unused),
        .empty_o           (fifo_empty),
        .cnt_o             (cnt_q),
        .data_i            (sel),
        .push_i            (handshake),
        .data_o            (head),
        .pop_i             (pop)
    );

`ifdef CV32E40P_ASSERT_ON
    a_no_rvalid_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        bus.instr_rvalid_i |-> !fifo_empty);
    a_locked_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        lock_q |-> sel_req);
    a_addr_stable_while_waited: assert property (@(posedge clk) disable iff (!rst_n)
        lock_q |-> (bus.instr_addr_o == $past(bus.instr_addr_o)));
    a_single_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.m0_gnt_o && bus.m1_gnt_o));
`endif

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
// tb/tb_cv32e40p_instr_obi_arbiter.sv - self-checking bench for the instruction OBI arbiter
module tb_cv32e40p_instr_obi_arbiter;

    localparam int MAX = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cv32e40p_instr_obi_arbiter_if bus ();

    cv32e40p_instr_obi_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                         input logic g, input logic rv, input logic [31:0] rd);
        bus.m0_req_i      = r0;
        bus.m0_addr_i     = a0;
        bus.m1_req_i      = r1;
        bus.m1_addr_i     = a1;
        bus.instr_gnt_i   = g;
        bus.instr_rvalid_i = rv;
        bus.instr_rdata_i = rd;
        bus.instr_err_i   = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h104, 1'b1, 32'h208, 1'b1, 1'b1, 32'hdeadbeef);
        bus.instr_err_i = 1'b1;
        settle();
        total++; if ({bus.instr_req_o, bus.m0_gnt_o, bus.m1_gnt_o} !== 3'b000) begin bad++;
            $display("FAIL reset_req_gnt: got %b want 000", {bus.instr_req_o, bus.m0_gnt_o, bus.m1_gnt_o}); end
        total++; if ({bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m_err_o, bus.busy_o} !== 4'b0000) begin bad++;
            $display("FAIL reset_rvalid_err_busy: got %b want 0000", {bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m_err_o, bus.busy_o}); end
        total++; if (bus.instr_addr_o !== 32'h0) begin bad++;
            $display("FAIL reset_addr: got %h want 00000000", bus.instr_addr_o); end
        total++; if (bus.m_rdata_o !== 32'h0) begin bad++;
            $display("FAIL reset_rdata: got %h want 00000000", bus.m_rdata_o); end
        step();
        idle();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_master();
        logic [31:0] data [3];
        data[0] = 32'h1111_0000;
        data[1] = 32'h2222_0004;
        data[2] = 32'h3333_0008;
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, 32'h100 + 32'(4 * i), 1'b0, 32'h0, i < 3, (i >= 1) && (i <= 3),
                  ((i >= 1) && (i <= 3)) ? data[(i > 0) ? i - 1 : 0] : 32'h0);
            settle();
            if (i < 3) begin
                total++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h100 + 32'(4 * i)) begin bad++;
                    $display("FAIL single_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, bus.instr_req_o, bus.instr_addr_o, 32'h100 + 32'(4 * i)); end
                total++; if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0) begin bad++;
                    $display("FAIL single_gnt[%0d]: got g0=%b g1=%b want g0=1 g1=0", i, bus.m0_gnt_o, bus.m1_gnt_o); end
            end
            if (i >= 1 && i <= 3) begin
                total++; if (bus.m0_rvalid_o !== 1'b1 || bus.m_rdata_o !== data[i - 1]) begin bad++;
                    $display("FAIL single_resp[%0d]: got rv0=%b rdata=%h want rv0=1 rdata=%h", i, bus.m0_rvalid_o, bus.m_rdata_o, data[i - 1]); end
            end
            total++; if (bus.m1_rvalid_o !== 1'b0) begin bad++;
                $display("FAIL single_m1_rvalid[%0d]: got %b want 0", i, bus.m1_rvalid_o); end
            total++; if (bus.busy_o !== ((i >= 1) && (i <= 3))) begin bad++;
                $display("FAIL single_busy[%0d]: got %b want %b", i, bus.busy_o, (i >= 1) && (i <= 3)); end
            step();
        end
        idle();
    endtask

    task automatic test_contention();
        int owner;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, 32'h1000 + 32'(4 * i), i < 4, 32'h2000 + 32'(4 * i), i < 4, i >= 1, 32'(i));
            settle();
            if (i < 4) begin
                total++; if (bus.m0_gnt_o !== (i % 2 == 0) || bus.m1_gnt_o !== (i % 2 == 1)) begin bad++;
                    $display("FAIL contention_gnt[%0d]: got g0=%b g1=%b want g0=%b g1=%b", i, bus.m0_gnt_o, bus.m1_gnt_o, i % 2 == 0, i % 2 == 1); end
                total++; if (bus.instr_addr_o !== ((i % 2 == 1) ? 32'h2000 : 32'h1000) + 32'(4 * i)) begin bad++;
                    $display("FAIL contention_addr[%0d]: got %h", i, bus.instr_addr_o); end
            end
            if (i >= 1) begin
                owner = (i - 1) % 2;
                total++; if (bus.m0_rvalid_o !== (owner == 0) || bus.m1_rvalid_o !== (owner == 1)) begin bad++;
                    $display("FAIL contention_route[%0d]: got rv0=%b rv1=%b want owner m%0d", i, bus.m0_rvalid_o, bus.m1_rvalid_o, owner); end
            end
            step();
        end
        idle();
    endtask

    task automatic test_lock();
        drive(1'b1, 32'h1f0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        total++; if (bus.m0_gnt_o !== 1'b1) begin bad++; $display("FAIL lock_pre_gnt: got %b want 1", bus.m0_gnt_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200, i >= 1, 32'h300, 1'b0, 1'b0, 32'h0);
            settle();
            total++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h200) begin bad++;
                $display("FAIL lock_hold[%0d]: got req=%b addr=%h want req=1 addr=00000200", i, bus.instr_req_o, bus.instr_addr_o); end
            total++; if (bus.m0_gnt_o !== 1'b0 || bus.m1_gnt_o !== 1'b0) begin bad++;
                $display("FAIL lock_no_gnt[%0d]: got g0=%b g1=%b want 0 0", i, bus.m0_gnt_o, bus.m1_gnt_o); end
            step();
        end
        drive(1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
        settle();
        total++; if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0 || bus.instr_addr_o !== 32'h200) begin bad++;
            $display("FAIL lock_release: got g0=%b g1=%b addr=%h want 1 0 00000200", bus.m0_gnt_o, bus.m1_gnt_o, bus.instr_addr_o); end
        step();
        drive(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
        settle();
        total++; if (bus.m1_gnt_o !== 1'b1 || bus.instr_addr_o !== 32'h300) begin bad++;
            $display("FAIL lock_m1_next: got g1=%b addr=%h want 1 00000300", bus.m1_gnt_o, bus.instr_addr_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h66);
        settle();
        total++; if (bus.m0_rvalid_o !== 1'b1 || bus.m1_rvalid_o !== 1'b0) begin bad++;
            $display("FAIL lock_resp0: got rv0=%b rv1=%b want 1 0", bus.m0_rvalid_o, bus.m1_rvalid_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77);
        settle();
        total++; if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b1) begin bad++;
            $display("FAIL lock_resp1: got rv0=%b rv1=%b want 0 1", bus.m0_rvalid_o, bus.m1_rvalid_o); end
        step();
        idle();
    endtask

    task automatic test_outstanding_limit();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0, 32'h0);
            settle();
            total++; if (bus.m1_gnt_o !== 1'b1) begin bad++; $display("FAIL limit_gnt[%0d]: got %b want 1", i, bus.m1_gnt_o); end
            step();
        end
        drive(1'b0, 32'h0, 1'b1, 32'h408, 1'b1, 1'b0, 32'h0);
        settle();
        total++; if (bus.instr_req_o !== 1'b0 || bus.m1_gnt_o !== 1'b0 || bus.busy_o !== 1'b1) begin bad++;
            $display("FAIL limit_full: got req=%b g1=%b busy=%b want 0 0 1", bus.instr_req_o, bus.m1_gnt_o, bus.busy_o); end
        step();
        drive(1'b0, 32'h0, 1'b1, 32'h408, 1'b1, 1'b1, 32'ha1);
        settle();
        total++; if (bus.instr_req_o !== 1'b0 || bus.m1_rvalid_o !== 1'b1) begin bad++;
            $display("FAIL limit_pop_same_cycle: got req=%b rv1=%b want 0 1", bus.instr_req_o, bus.m1_rvalid_o); end
        step();
        drive(1'b0, 32'h0, 1'b1, 32'h408, 1'b1, 1'b0, 32'h0);
        settle();
        total++; if (bus.instr_req_o !== 1'b1 || bus.m1_gnt_o !== 1'b1) begin bad++;
            $display("FAIL limit_reopen: got req=%b g1=%b want 1 1", bus.instr_req_o, bus.m1_gnt_o); end
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hb0 + 32'(i));
            settle();
            total++; if (bus.m1_rvalid_o !== 1'b1) begin bad++; $display("FAIL limit_drain[%0d]: got %b want 1", i, bus.m1_rvalid_o); end
            step();
        end
        idle();
        settle();
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL limit_idle_busy: got %b want 0", bus.busy_o); end
        step();
    endtask

    task automatic test_push_pop();
        drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        total++; if (bus.m0_gnt_o !== 1'b1) begin bad++; $display("FAIL pushpop_first_gnt: got %b want 1", bus.m0_gnt_o); end
        step();
        drive(1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 1'b1, 32'hc0de_0001);
        settle();
        total++; if (bus.m1_gnt_o !== 1'b1 || bus.m0_rvalid_o !== 1'b1 || bus.m1_rvalid_o !== 1'b0) begin bad++;
            $display("FAIL pushpop_both: got g1=%b rv0=%b rv1=%b want 1 1 0", bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o); end
        total++; if (bus.m_rdata_o !== 32'hc0de_0001) begin bad++;
            $display("FAIL pushpop_rdata: got %h want c0de0001", bus.m_rdata_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hc0de_0002);
        settle();
        total++; if (bus.m1_rvalid_o !== 1'b1 || bus.m0_rvalid_o !== 1'b0 || bus.busy_o !== 1'b1) begin bad++;
            $display("FAIL pushpop_queued: got rv1=%b rv0=%b busy=%b want 1 0 1", bus.m1_rvalid_o, bus.m0_rvalid_o, bus.busy_o); end
        step();
        idle();
        settle();
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL pushpop_count_one: got busy=%b want 0", bus.busy_o); end
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            step();
        end
        drive(1'b1, 32'h708, 1'b1, 32'h800, 1'b1, 1'b1, 32'hfeed_f00d);
        bus.instr_err_i = 1'b1;
        rst_n = 1'b0;
        settle();
        total++; if ({bus.instr_req_o, bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m_err_o, bus.busy_o} !== 7'b0) begin bad++;
            $display("FAIL midreset_ctrl: got %b want 0000000", {bus.instr_req_o, bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m_err_o, bus.busy_o}); end
        total++; if (bus.instr_addr_o !== 32'h0 || bus.m_rdata_o !== 32'h0) begin bad++;
            $display("FAIL midreset_data: got addr=%h rdata=%h want 0 0", bus.instr_addr_o, bus.m_rdata_o); end
        step();
        idle();
        step();
        rst_n = 1'b1;
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hbad0);
        settle();
        total++; if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0 || bus.busy_o !== 1'b0) begin bad++;
            $display("FAIL midreset_late_rvalid: got rv0=%b rv1=%b busy=%b want 0 0 0", bus.m0_rvalid_o, bus.m1_rvalid_o, bus.busy_o); end
        step();
        drive(1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        total++; if (bus.m0_gnt_o !== 1'b1 || bus.instr_addr_o !== 32'h900) begin bad++;
            $display("FAIL midreset_fresh_gnt: got g0=%b addr=%h want 1 00000900", bus.m0_gnt_o, bus.instr_addr_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h9999);
        settle();
        total++; if (bus.m0_rvalid_o !== 1'b1) begin bad++; $display("FAIL midreset_fresh_resp: got %b want 1", bus.m0_rvalid_o); end
        step();
        idle();
    endtask

    // Reference: owners queue in grant order; ties alternate; a waiting request keeps its master
    task automatic test_random();
        int          owners [$];
        int          last_m;
        bit          locked;
        int          lock_m;
        logic [31:0] held [2];
        bit          r0, r1, g, rv, er;
        logic [31:0] a0, a1, rd, saddr;
        int          s;
        bit          sreq, ereq;
        do_reset();
        last_m = 1;
        locked = 1'b0;
        lock_m = 0;
        for (int n = 0; n < 2000; n++) begin
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            a0 = $urandom;
            a1 = $urandom;
            if (locked && lock_m == 0) begin r0 = 1'b1; a0 = held[0]; end
            if (locked && lock_m == 1) begin r1 = 1'b1; a1 = held[1]; end
            g  = ($urandom_range(0, 3) != 0);
            rv = (owners.size() > 0) && ($urandom_range(0, 1) == 1);
            rd = $urandom;
            er = ($urandom_range(0, 1) == 1);
            drive(r0, a0, r1, a1, g, rv, rd);
            bus.instr_err_i = er;
            if (locked)        s = lock_m;
            else if (r0 && r1) s = 1 - last_m;
            else if (r1)       s = 1;
            else               s = 0;
            sreq  = (s == 1) ? r1 : r0;
            saddr = (s == 1) ? a1 : a0;
            ereq  = sreq && (owners.size() < MAX);
            settle();
            total++; if (bus.instr_req_o !== ereq) begin bad++;
                $display("FAIL rand_req[%0d]: got %b want %b", n, bus.instr_req_o, ereq); end
            if (sreq) begin
                total++; if (bus.instr_addr_o !== {saddr[31:2], 2'b00}) begin bad++;
                    $display("FAIL rand_addr[%0d]: got %h want %h", n, bus.instr_addr_o, {saddr[31:2], 2'b00}); end
            end
            total++; if (bus.m0_gnt_o !== (ereq && g && s == 0) || bus.m1_gnt_o !== (ereq && g && s == 1)) begin bad++;
                $display("FAIL rand_gnt[%0d]: got g0=%b g1=%b want g0=%b g1=%b", n, bus.m0_gnt_o, bus.m1_gnt_o, ereq && g && s == 0, ereq && g && s == 1); end
            total++; if (bus.m0_rvalid_o !== (rv && owners[0] == 0) || bus.m1_rvalid_o !== (rv && owners[0] == 1)) begin bad++;
                $display("FAIL rand_route[%0d]: got rv0=%b rv1=%b want rv0=%b rv1=%b", n, bus.m0_rvalid_o, bus.m1_rvalid_o, rv && owners[0] == 0, rv && owners[0] == 1); end
            if (rv) begin
                total++; if (bus.m_rdata_o !== rd || bus.m_err_o !== er) begin bad++;
                    $display("FAIL rand_data[%0d]: got %h/%b want %h/%b", n, bus.m_rdata_o, bus.m_err_o, rd, er); end
            end
            total++; if (bus.busy_o !== (owners.size() != 0)) begin bad++;
                $display("FAIL rand_busy[%0d]: got %b want %b", n, bus.busy_o, owners.size() != 0); end
            if (rv) void'(owners.pop_front());
            if (ereq && g) begin
                owners.push_back(s);
                last_m = s;
            end
            locked = ereq && !g;
            if (locked) begin
                lock_m = s;
                held[s] = saddr;
            end
            step();
        end
        for (int i = 0; i < MAX && owners.size() > 0; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
            void'(owners.pop_front());
            step();
        end
        idle();
        settle();
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rand_drained_busy: got %b want 0", bus.busy_o); end
        step();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_single_master();
        test_contention();
        test_lock();
        test_outstanding_limit();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cv32e40p_instr_obi_arbiter.md
# cv32e40p_instr_obi_arbiter

Two-master, in-order arbiter that shares the single instruction-side OBI port between the prefetch buffer (master 0) and a secondary fetcher such as a debug program-buffer or icache-refill engine (master 1). It sits between the requesters' OBI ports and the core's `instr_*` bus. Arbitration is round-robin and locked across waited transfers. A small owner FIFO tracks outstanding transactions so each in-order response is routed back to the master that issued it.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions across both masters; power of 2, ≥ 1.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req_i  in  1  master 0 (prefetcher) request.
- m0_addr_i  in  32  master 0 word address.
- m0_gnt_o  out  1  master 0 grant.
- m0_rvalid_o  out  1  master 0 response valid.
- m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o: same as above, for master 1.
- m_rdata_o  out  32  response data, broadcast to both masters.
- m_err_o  out  1  response error, broadcast to both masters.
- instr_req_o  out  1  bus request.
- instr_addr_o  out  32  bus address.
- instr_gnt_i  in  1  bus grant.
- instr_rvalid_i  in  1  bus response valid.
- instr_rdata_i  in  32  bus response data.
- instr_err_i  in  1  bus response error.
- busy_o  out  1  high when the outstanding count is non-zero.

## Operation
- **Arbitration state**
  - `last_q`: the last master granted; resets to 1, so master 0 wins the first tie.
  - `lock_q` and `lock_id_q`: the lock flag and locked master.
- **Selection**
  - If `lock_q` is set, select `lock_id_q`.
  - Otherwise, if only one master requests, select that master.
  - Otherwise, if both request, select `~last_q`.
- **Bus request**
  - `instr_req_o = sel_req && (cnt_q < MAX_OUTSTANDING)`.
  - `instr_addr_o = sel_addr`, with bits [1:0] forced to 0.
- **Grant**
  - `mX_gnt_o = instr_gnt_i && instr_req_o && (sel == X)`.
  - Never grant the non-selected master.
- **Lock**
  - Set when `instr_req_o && !instr_gnt_i`; `lock_id_q` is set to `sel`.
  - Clear on the grant cycle.
  - This keeps the address and owner stable through waited transfers, as OBI requires.
  - A master dropping `req` while locked is a protocol violation (assertion); the lock clears on the next cycle.
- **Handshake**
  - On `instr_req_o && instr_gnt_i`: push `sel` into the owner FIFO, update `last_q`, and increment `cnt_q`.
- **Response**
  - On `instr_rvalid_i`: pop the FIFO head and drive `m<head>_rvalid_o = 1`.
  - Data and error pass straight through, with no registering.
- **Simultaneous push and pop:** `cnt_q` is unchanged.
- **Full:** the `cnt_q < MAX_OUTSTANDING` check uses the registered count only. No combinational path from `instr_rvalid_i` to `instr_req_o`, so a pop does not free a slot in the same cycle.
- **`instr_rvalid_i` while the FIFO is empty:** protocol violation (assertion); the response is dropped and no `mX_rvalid_o` is raised.
- **Reset:** all state clears (`cnt_q = 0`, `lock_q = 0`, FIFO empty, `last_q = 1`).
  - Every output is 0 while `rst_n` is low.
  - Reset asserted mid-transaction discards all outstanding ownership; the bus side must be reset together with the arbiter.

## Timing
- Request path is combinational: master request to `instr_req_o` and `instr_addr_o` in the same cycle, zero added latency.
- Grant path: `instr_gnt_i` to `mX_gnt_o` is combinational.
- Response path: `instr_rvalid_i` to `mX_rvalid_o` is combinational, driven by the registered FIFO head.
- Back-to-back grants: one per cycle while `cnt_q < MAX_OUTSTANDING`.
- With MAX_OUTSTANDING = 2 and single-cycle memory, one master sustains 1 request per cycle.
- Under contention, masters alternate every granted transfer.
- All state updates occur on the `clk` rising edge.

## Structure
- Add `INSTR_ARB_M0 = 1'b0` and `INSTR_ARB_M1 = 1'b1` to `cv32e40p_pkg`; no other typedefs.
- Owner FIFO: instantiate `cv32e40p_fifo` with `FALL_THROUGH = 0`, `DATA_WIDTH = 1`, `DEPTH = MAX_OUTSTANDING`.
  - Its `cnt_o` serves as `cnt_q`.
  - Tie `flush_i`, `flush_but_first_i` and `testmode_i` to 0.
- Arbitration, lock and routing logic stay in this module, about 150 lines.
- Assertions go under `CV32E40P_ASSERT_ON`:
  - No `rvalid` while the FIFO is empty.
  - Locked `req` is stable.
  - `instr_addr_o` is stable while waited.
  - At most one `mX_gnt_o` per cycle.

## Test plan
- **Single master, zero-wait memory:** m0 requests 0x100, 0x104, 0x108 back-to-back → three grants on consecutive cycles; m0 receives rdata in order; m1 never sees `rvalid`; `busy_o` falls after the last response.
- **Contention:** m0 and m1 request continuously after reset → grant order m0, m1, m0, m1; each `rvalid` is routed to the matching master.
- **Waited transfer lock:** m0 requests 0x200 with `instr_gnt_i` low for 3 cycles while m1 raises `req` in cycle 2 → `instr_addr_o` holds 0x200; m1 is not granted until the m0 grant; m1 is granted the next cycle.
- **Outstanding limit:** MAX_OUTSTANDING = 2, no `rvalid`, m1 issues 2 granted requests → `instr_req_o` is low on the 3rd request. An `rvalid` arrives → `instr_req_o` rises in the following cycle, not the same cycle.
- **Simultaneous push and pop with cnt = 1:** `rvalid` and a new grant occur in the same cycle → `cnt` stays 1; the response goes to the old owner and the new owner is queued.
- **Reset mid-operation:** 2 requests outstanding, `rst_n` pulsed low → all outputs 0; after release, a late `instr_rvalid_i` triggers the empty-FIFO assertion; a fresh m0 request is granted normally.
